// File: rtl/demux_1x4_stream.sv
// demux_1x4_stream: registered 1-to-4 stream demultiplexer.
// Each accepted input beat is steered by in_sel into a one-entry holding
// register on one of four output channels, each with its own valid/ready
// handshake. A stalled consumer only blocks beats addressed to it.
// Optional feature macro: DEMUX_BEAT_CNT_EN adds four saturating 8-bit
// per-channel output transfer counters on the beat_cnt port.
module demux_1x4_stream #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  input  logic [1:0]     in_sel,
  output logic [3:0]     out_valid,
  input  logic [3:0]     out_ready,
  output logic [4*W-1:0] out_data
`ifdef DEMUX_BEAT_CNT_EN
  ,
  output logic [31:0]    beat_cnt
`endif
);

  logic       in_fire;
  logic [3:0] load;
  logic [3:0] drain;

  // The addressed channel can take a beat if it is empty or is being drained
  // this cycle; in_valid deliberately does not feed back into in_ready.
  always_comb begin
    in_ready = !out_valid[in_sel] || out_ready[in_sel];
    in_fire  = in_valid && in_ready;
    load     = 4'b0000;
    if (in_fire) begin
      load[in_sel] = 1'b1;
    end
    drain = out_valid & out_ready;
  end

  // Per-channel holding registers: a load wins over a drain so a channel
  // can be refilled in the same cycle it empties, giving full throughput.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 4'b0000;
      out_data  <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (load[k]) begin
          out_data[k*W +: W] <= in_data;
        end
        out_valid[k] <= load[k] || (out_valid[k] && !out_ready[k]);
      end
    end
  end

`ifdef DEMUX_BEAT_CNT_EN
  // Count completed output transfers per channel, sticking at 255.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (drain[k] && (beat_cnt[k*8 +: 8] != 8'hFF)) begin
          beat_cnt[k*8 +: 8] <= beat_cnt[k*8 +: 8] + 8'd1;
        end
      end
    end
  end
`else
  // Without the counters the drain vector has no consumer.
  logic unused_drain;
  assign unused_drain = ^drain;
`endif

endmodule

// File: tb/tb_demux_1x4_stream.sv
// Self-checking bench for demux_1x4_stream (W = 8).
// Per-channel scoreboard queues receive a beat when the bench's own model
// says the input handshake completes, and are popped when the model says the
// channel drains. Every sampled cycle the DUT is compared against the queues.
module tb_demux_1x4_stream;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data;
`ifdef DEMUX_BEAT_CNT_EN
  logic [31:0] beat_cnt;
  int          exp_cnt [4];
`endif

  logic [7:0] exp_q [4][$];
  int         compared;
  int         mismatched;

  demux_1x4_stream #(.W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef DEMUX_BEAT_CNT_EN
    ,
    .beat_cnt  (beat_cnt)
`endif
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic [1:0] s,
                               input logic [3:0] r);
    in_valid  = v;
    in_data   = d;
    in_sel    = s;
    out_ready = r;
  endtask

  // Compare the DUT against the scoreboard, then advance the model to what
  // the coming rising edge will do.
  task automatic checkOutput();
    logic exp_ready;
    for (int k = 0; k < 4; k++) begin
      if (exp_q[k].size() > 0) begin
        check($sformatf("valid[%0d]", k), {31'd0, out_valid[k]}, 32'd1);
        check($sformatf("data[%0d]", k), {24'd0, out_data[k*8 +: 8]}, {24'd0, exp_q[k][0]});
      end else begin
        check($sformatf("idle_valid[%0d]", k), {31'd0, out_valid[k]}, 32'd0);
      end
`ifdef DEMUX_BEAT_CNT_EN
      check($sformatf("beat_cnt[%0d]", k), {24'd0, beat_cnt[k*8 +: 8]}, exp_cnt[k]);
`endif
    end
    exp_ready = (exp_q[in_sel].size() == 0) || out_ready[in_sel];
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        exp_q[k].delete();
`ifdef DEMUX_BEAT_CNT_EN
        exp_cnt[k] = 0;
`endif
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (exp_q[k].size() > 0 && out_ready[k]) begin
          void'(exp_q[k].pop_front());
`ifdef DEMUX_BEAT_CNT_EN
          if (exp_cnt[k] < 255) exp_cnt[k]++;
`endif
        end
      end
      if (in_valid && exp_ready) begin
        exp_q[in_sel].push_back(in_data);
      end
    end
  endtask

  task automatic cycle(input logic v, input logic [7:0] d, input logic [1:0] s,
                       input logic [3:0] r);
    applyStimulus(v, d, s, r);
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  // Directed sequence of steps.
  initial begin
    compared   = 0;
    mismatched = 0;
`ifdef DEMUX_BEAT_CNT_EN
    for (int k = 0; k < 4; k++) exp_cnt[k] = 0;
`endif

    // Reset for two cycles while a beat is offered.
    rst = 1'b1;
    applyStimulus(1'b1, 8'hEE, 2'd0, 4'b0000);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b0, 8'h00, 2'd0, 4'b0000);
    @(negedge clk);
    check("reset_valid", {28'd0, out_valid}, 32'd0);
    check("reset_data", out_data, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef DEMUX_BEAT_CNT_EN
    check("reset_beat_cnt", beat_cnt, 32'd0);
`endif
    @(posedge clk);
    #1;

    // Basic steer to each channel with all consumers ready.
    cycle(1'b1, 8'hA0, 2'd0, 4'b1111);
    cycle(1'b1, 8'hA1, 2'd1, 4'b1111);
    cycle(1'b1, 8'hA2, 2'd2, 4'b1111);
    cycle(1'b1, 8'hA3, 2'd3, 4'b1111);
    cycle(1'b0, 8'h00, 2'd0, 4'b1111);
    cycle(1'b0, 8'h00, 2'd0, 4'b1111);

    // Backpressure on channel 2 must not block channel 0.
    cycle(1'b1, 8'h11, 2'd2, 4'b1011);
    cycle(1'b1, 8'h22, 2'd2, 4'b1011);
    cycle(1'b1, 8'h22, 2'd2, 4'b1011);
    cycle(1'b1, 8'h33, 2'd0, 4'b1011);
    cycle(1'b0, 8'h00, 2'd0, 4'b1011);
    cycle(1'b1, 8'h22, 2'd2, 4'b1111);
    cycle(1'b0, 8'h00, 2'd0, 4'b1111);
    cycle(1'b0, 8'h00, 2'd0, 4'b1111);

    // Load and drain channel 1 in the same cycle.
    cycle(1'b1, 8'h55, 2'd1, 4'b0000);
    cycle(1'b0, 8'h00, 2'd1, 4'b0000);
    cycle(1'b1, 8'h66, 2'd1, 4'b0010);
    cycle(1'b0, 8'h00, 2'd1, 4'b0000);
    cycle(1'b0, 8'h00, 2'd0, 4'b1111);

    // Fill every channel, then reset with a beat offered.
    cycle(1'b1, 8'hC0, 2'd0, 4'b0000);
    cycle(1'b1, 8'hC1, 2'd1, 4'b0000);
    cycle(1'b1, 8'hC2, 2'd2, 4'b0000);
    cycle(1'b1, 8'hC3, 2'd3, 4'b0000);
    rst = 1'b1;
    cycle(1'b1, 8'hDD, 2'd0, 4'b0000);
    rst = 1'b0;
    check("midreset_valid", {28'd0, out_valid}, 32'd0);
    cycle(1'b0, 8'h00, 2'd0, 4'b1111);
    cycle(1'b0, 8'h00, 2'd0, 4'b1111);
    cycle(1'b0, 8'h00, 2'd0, 4'b1111);

`ifdef DEMUX_BEAT_CNT_EN
    // 300 back-to-back transfers on channel 3 saturate its counter only.
    rst = 1'b1;
    cycle(1'b0, 8'h00, 2'd0, 4'b0000);
    rst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      cycle(1'b1, i[7:0], 2'd3, 4'b1000);
    end
    cycle(1'b0, 8'h00, 2'd3, 4'b1000);
    cycle(1'b0, 8'h00, 2'd3, 4'b1000);
    check("cnt_saturated", beat_cnt, {8'd255, 24'd0});
`endif

    for (int k = 0; k < 4; k++) begin
      check($sformatf("drained[%0d]", k), exp_q[k].size(), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
